// File: rtl/speed_level_scheduler.sv
// speed_level_scheduler: game-speed prescaler with tick generation and level promotion
module speed_level_scheduler #(
  parameter int SPEEDCOMPARATOR_DATAWIDTH = 25,
  parameter int LEVELWIDTH                = 2,
  parameter int LEVELSTEP                 = 4194304,
  parameter int TICKS_PER_LEVEL           = 16
) (
  input  logic                                 SPEED_LEVEL_SCHEDULER_CLOCK_50,
  input  logic                                 SPEED_LEVEL_SCHEDULER_RESET_InHigh,
  input  logic                                 SPEED_LEVEL_SCHEDULER_start_InHigh,
  input  logic                                 SPEED_LEVEL_SCHEDULER_stop_InHigh,
  input  logic                                 SPEED_LEVEL_SCHEDULER_pause_InHigh,
  output logic [SPEEDCOMPARATOR_DATAWIDTH-1:0] SPEED_LEVEL_SCHEDULER_count_OutBUS,
  output logic                                 SPEED_LEVEL_SCHEDULER_tick_OutHigh,
  output logic                                 SPEED_LEVEL_SCHEDULER_levelup_OutHigh,
  output logic [LEVELWIDTH-1:0]                SPEED_LEVEL_SCHEDULER_level_OutBUS,
  output logic                                 SPEED_LEVEL_SCHEDULER_running_OutHigh,
  output logic                                 SPEED_LEVEL_SCHEDULER_maxlevel_OutHigh
);
  localparam int W        = SPEEDCOMPARATOR_DATAWIDTH;
  localparam int MAXLEVEL = 2**LEVELWIDTH - 1;
  localparam int TW       = $clog2(TICKS_PER_LEVEL + 1);
  // the highest reload must leave at least one counting step before all-ones
  if (longint'(MAXLEVEL) * longint'(LEVELSTEP) >= (longint'(1) << W) - 1 || TICKS_PER_LEVEL < 1) begin : g_bad_params
    $error("speed_level_scheduler: illegal parameter set");
  end
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t                r_state, w_state;
  logic [W-1:0]          r_count, w_count;
  logic [LEVELWIDTH-1:0] r_level, w_level;
  logic [TW-1:0]         r_tcnt, w_tcnt;
  logic                  r_tick, w_tick, r_levelup, w_levelup, r_running, r_maxlevel;
  logic                  w_wrap, w_promote;
  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_level   = r_level;
    w_tcnt    = r_tcnt;
    w_tick    = 1'b0;
    w_levelup = 1'b0;
    w_wrap    = &r_count;
    w_promote = w_wrap && (r_tcnt == TW'(TICKS_PER_LEVEL - 1));
    if (SPEED_LEVEL_SCHEDULER_stop_InHigh) begin
      w_state = IDLE;
      w_count = '0;
      w_level = '0;
      w_tcnt  = '0;
    end else if (r_state == IDLE) begin
      w_state = SPEED_LEVEL_SCHEDULER_start_InHigh ? RUN : IDLE;
      w_count = '0;
    end else if (SPEED_LEVEL_SCHEDULER_pause_InHigh) begin
      w_state = PAUSE;
    end else begin
      // the release edge itself counts, so an N-cycle pause costs exactly N cycles
      w_state = RUN;
      w_tick  = w_wrap;
      if (w_wrap) begin
        w_tcnt    = w_promote ? '0 : r_tcnt + TW'(1);
        w_levelup = w_promote && (r_level != LEVELWIDTH'(MAXLEVEL));
        w_level   = r_level + LEVELWIDTH'(w_levelup);
        w_count   = W'(LEVELSTEP * int'(w_level));
      end else begin
        w_count = r_count + W'(1);
      end
    end
  end
  always_ff @(posedge SPEED_LEVEL_SCHEDULER_CLOCK_50) begin
    if (SPEED_LEVEL_SCHEDULER_RESET_InHigh) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_level    <= '0;
      r_tcnt     <= '0;
      r_tick     <= 1'b0;
      r_levelup  <= 1'b0;
      r_running  <= 1'b0;
      r_maxlevel <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_count    <= w_count;
      r_level    <= w_level;
      r_tcnt     <= w_tcnt;
      r_tick     <= w_tick;
      r_levelup  <= w_levelup;
      r_running  <= w_state != IDLE;
      r_maxlevel <= w_level == LEVELWIDTH'(MAXLEVEL);
    end
  end
  assign SPEED_LEVEL_SCHEDULER_count_OutBUS    = r_count;
  assign SPEED_LEVEL_SCHEDULER_tick_OutHigh     = r_tick;
  assign SPEED_LEVEL_SCHEDULER_levelup_OutHigh  = r_levelup;
  assign SPEED_LEVEL_SCHEDULER_level_OutBUS     = r_level;
  assign SPEED_LEVEL_SCHEDULER_running_OutHigh  = r_running;
  assign SPEED_LEVEL_SCHEDULER_maxlevel_OutHigh = r_maxlevel;
endmodule
